// File: rtl/nn_pkg.sv
// nn_pkg: shared types and helpers for the dense-layer block.
//   state_e    - layer sequencer states
//   sat_w()    - clamp a wide signed value to the signed range of a w-bit word
//   WeightBase - first configuration address of the weight table
//   bias_base  - first configuration address of the bias table
package nn_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StPost,
    StDone
  } state_e;

  // Widest value sat_w() can take; the MAC post stage needs ACC_W+1 bits.
  localparam int unsigned SatW = 64;

  // Weights occupy j*N_IN+i from here; biases follow the whole weight table.
  localparam int unsigned WeightBase = 0;

  function automatic int unsigned bias_base(input int unsigned n_in, input int unsigned n_out);
    return WeightBase + n_in * n_out;
  endfunction

  function automatic logic signed [SatW-1:0] sat_w(input logic signed [SatW-1:0] acc,
                                                   input int unsigned w);
    logic signed [SatW-1:0] hi;
    logic signed [SatW-1:0] lo;
    hi = $signed((64'd1 << (w - 1)) - 64'd1);
    lo = -hi - 64'sd1;
    if (acc > hi) begin
      return hi;
    end else if (acc < lo) begin
      return lo;
    end
    return acc;
  endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// nn_mac_unit: shared multiply-accumulate datapath plus the per-neuron post stage.
//   clk, rst  - clock, synchronous active-high reset
//   i_clr     - clear the accumulator (has priority over i_acc_en)
//   i_acc_en  - add i_w * i_x (full signed product) to the accumulator
//   i_w, i_x  - weight and input element
//   i_bias    - neuron bias, same Q format as the data
//   i_relu    - clamp negative results to zero
//   o_result  - (acc + bias<<FRAC) >>> FRAC, optional ReLU, saturated to W bits
module nn_mac_unit
  import nn_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned ACC_W = 2 * W + 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_acc_en,
  input  logic [W-1:0] i_w,
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_bias,
  input  logic         i_relu,
  output logic [W-1:0] o_result
);

  logic signed [ACC_W-1:0] r_acc;
  logic signed [2*W-1:0]   w_prod;
  logic signed [ACC_W:0]   w_bias_sh;
  logic signed [ACC_W:0]   w_sum;
  logic signed [ACC_W:0]   w_shr;
  logic signed [ACC_W:0]   w_relu;
  logic signed [SatW-1:0]  w_sat;
  logic                    w_unused_sat;

  assign w_prod = $signed(i_w) * $signed(i_x);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_acc_en) begin
      r_acc <= r_acc + {{(ACC_W - 2 * W){w_prod[2*W-1]}}, w_prod};
    end
  end

  // One extra bit of headroom so adding the aligned bias can never wrap.
  assign w_bias_sh = {{(ACC_W + 1 - W){i_bias[W-1]}}, i_bias} << FRAC;
  assign w_sum     = {r_acc[ACC_W-1], r_acc} + w_bias_sh;
  assign w_shr     = w_sum >>> FRAC;
  assign w_relu    = (i_relu && w_shr[ACC_W]) ? '0 : w_shr;
  assign w_sat     = sat_w(SatW'(w_relu), W);
  assign o_result  = w_sat[W-1:0];

  // Bits above W are pure sign copies after saturation.
  assign w_unused_sat = ^w_sat[SatW-1:W];

endmodule

// File: rtl/nn_dense_layer.sv
// nn_dense_layer: sequential fixed-point fully-connected layer, one MAC shared by all neurons.
//   clk, rst  - clock, synchronous active-high reset
//   start     - evaluate the layer (accepted in IDLE only); relu_en and in_vec captured with it
//   in_vec    - N_IN elements of W bits, element i at [i*W +: W]
//   cfg_we    - config write (IDLE only): weight j*N_IN+i, bias N_IN*N_OUT+j
//   busy      - run in progress (cycle after acceptance through the done cycle)
//   done      - one-cycle pulse, out_vec valid
//   out_vec   - N_OUT results, element j at [j*W +: W]
module nn_dense_layer
  import nn_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 4,
  parameter int unsigned ACC_W = 2 * W + $clog2(N_IN) + 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   relu_en,
  input  logic [N_IN*W-1:0]                      in_vec,
  input  logic                                   cfg_we,
  input  logic [$clog2(N_IN*N_OUT+N_OUT)-1:0]    cfg_addr,
  input  logic [W-1:0]                           cfg_data,
  output logic                                   busy,
  output logic                                   done,
  output logic [N_OUT*W-1:0]                     out_vec
);

  localparam int unsigned NCfg     = N_IN * N_OUT + N_OUT;
  localparam int unsigned AW       = $clog2(NCfg);
  localparam int unsigned IW       = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned JW       = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int unsigned BiasBase = bias_base(N_IN, N_OUT);

  state_e         r_state;
  state_e         w_state_d;
  logic [IW-1:0]  r_i;
  logic [JW-1:0]  r_j;
  logic           r_relu;
  logic [W-1:0]   r_x   [N_IN];
  logic [W-1:0]   r_cfg [NCfg];
  // Snapshot of r_cfg taken at acceptance, so IDLE-time writes never disturb a run.
  logic [W-1:0]   r_run [NCfg];
  logic [W-1:0]   r_out [N_OUT];

  logic           w_accept;
  logic           w_last_i;
  logic           w_last_j;
  logic           w_cfg_ok;
  logic [AW-1:0]  w_widx;
  logic [AW-1:0]  w_bidx;
  logic [W-1:0]   w_post;

  assign w_accept = (r_state == StIdle) && start;
  assign w_last_i = (r_i == IW'(N_IN - 1));
  assign w_last_j = (r_j == JW'(N_OUT - 1));
  assign w_cfg_ok = cfg_we && (r_state == StIdle) && (32'(cfg_addr) < NCfg);
  assign w_widx   = AW'(WeightBase + r_j * N_IN + r_i);
  assign w_bidx   = AW'(BiasBase + r_j);

  always_comb begin
    w_state_d = r_state;
    busy      = (r_state != StIdle);
    done      = (r_state == StDone);
    unique case (r_state)
      StIdle:  if (start) w_state_d = StMac;
      StMac:   if (w_last_i) w_state_d = StPost;
      StPost:  w_state_d = w_last_j ? StDone : StMac;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_i     <= '0;
      r_j     <= '0;
      r_relu  <= 1'b0;
      for (int k = 0; k < N_IN; k++) r_x[k] <= '0;
      for (int k = 0; k < NCfg; k++) begin
        r_cfg[k] <= '0;
        r_run[k] <= '0;
      end
      for (int k = 0; k < N_OUT; k++) r_out[k] <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_cfg_ok) r_cfg[cfg_addr] <= cfg_data;
      if (w_accept) begin
        r_relu <= relu_en;
        r_i    <= '0;
        r_j    <= '0;
        r_run  <= r_cfg;
        for (int k = 0; k < N_IN; k++) r_x[k] <= in_vec[k*W +: W];
      end
      if (r_state == StMac) r_i <= w_last_i ? '0 : r_i + 1'b1;
      if (r_state == StPost) begin
        r_out[r_j] <= w_post;
        r_j        <= r_j + 1'b1;
        r_i        <= '0;
      end
    end
  end

  nn_mac_unit #(
    .W     (W),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_accept || (r_state == StPost)),
    .i_acc_en (r_state == StMac),
    .i_w      (r_run[w_widx]),
    .i_x      (r_x[r_i]),
    .i_bias   (r_run[w_bidx]),
    .i_relu   (r_relu),
    .o_result (w_post)
  );

  always_comb begin
    out_vec = '0;
    for (int k = 0; k < N_OUT; k++) out_vec[k*W +: W] = r_out[k];
  end

endmodule

// File: tb/tb_nn_dense_layer.sv
module tb_nn_dense_layer;
  localparam int unsigned W     = 16;
  localparam int unsigned FRAC  = 8;
  localparam int unsigned N_IN  = 2;
  localparam int unsigned N_OUT = 2;
  localparam int unsigned NCFG  = N_IN * N_OUT + N_OUT;
  localparam int unsigned AW    = 3;
  localparam int unsigned L     = N_OUT * (N_IN + 1);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  relu_en;
  logic [N_IN*W-1:0]     in_vec;
  logic                  cfg_we;
  logic [AW-1:0]         cfg_addr;
  logic [W-1:0]          cfg_data;
  logic                  busy;
  logic                  done;
  logic [N_OUT*W-1:0]    out_vec;

  nn_dense_layer #(
    .W     (W),
    .FRAC  (FRAC),
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .relu_en  (relu_en),
    .in_vec   (in_vec),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .busy     (busy),
    .done     (done),
    .out_vec  (out_vec)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint             m_cfg [NCFG];
  logic [N_OUT*W-1:0] m_pend;
  logic [N_OUT*W-1:0] m_held;
  bit                 m_active = 1'b0;
  bit                 m_busy = 1'b0;
  bit                 m_done = 1'b0;
  int                 m_edge = 0;
  int                 m_acc_edge = 0;

  function automatic logic [W-1:0] neuron(input longint acc, input longint bias, input bit relu);
    longint v;
    v = (acc + bias * (longint'(1) <<< FRAC)) >>> FRAC;
    if (relu && v < 0) v = 0;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return W'(v);
  endfunction

  task automatic model_step();
    bit     was_idle;
    longint x [N_IN];
    longint acc;
    m_edge++;
    if (rst) begin
      m_active = 1'b0;
      m_held   = '0;
      for (int k = 0; k < NCFG; k++) m_cfg[k] = 0;
    end else begin
      was_idle = !m_active;
      if (m_active && m_edge == m_acc_edge + L + 1) m_active = 1'b0;
      if (was_idle && start) begin
        for (int i = 0; i < N_IN; i++) x[i] = longint'($signed(in_vec[i*W +: W]));
        for (int j = 0; j < N_OUT; j++) begin
          acc = 0;
          for (int i = 0; i < N_IN; i++) acc += m_cfg[j*N_IN+i] * x[i];
          m_pend[j*W +: W] = neuron(acc, m_cfg[N_IN*N_OUT+j], relu_en);
        end
        m_active   = 1'b1;
        m_acc_edge = m_edge;
      end
      if (was_idle && cfg_we && cfg_addr < NCFG) m_cfg[cfg_addr] = longint'($signed(cfg_data));
    end
    m_busy = m_active;
    m_done = m_active && (m_edge == m_acc_edge + L);
    if (m_done) m_held = m_pend;
  endtask

  always @(posedge clk) model_step();

  task automatic compare_step();
    check("busy", 64'(busy), 64'(m_busy));
    check("done", 64'(done), 64'(m_done));
    if (!m_busy || m_done) check("out_vec", 64'(out_vec), 64'(m_held));
  endtask

  always @(negedge clk) compare_step();

  // ---------------- stimulus ----------------
  function automatic logic [W-1:0] rnd16();
    if ($urandom_range(0, 1) == 1) return W'($urandom);
    return W'(int'($urandom_range(0, 2047)) - 1024);
  endfunction

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(posedge clk);
    #1 cfg_we = 1'b0;
  endtask

  task automatic wr_basic();
    wr(0, 16'd128); wr(1, 16'd64); wr(2, 16'hFF00); wr(3, 16'd0); wr(4, 16'd256); wr(5, 16'd0);
  endtask

  task automatic run(input logic [W-1:0] x0, input logic [W-1:0] x1, input logic relu,
                     input bit busy_wr, input bit same_wr, input logic [AW-1:0] s_addr,
                     input logic [W-1:0] s_data, output int lat);
    @(negedge clk);
    in_vec  = {x1, x0};
    relu_en = relu;
    start   = 1'b1;
    if (same_wr) begin
      cfg_we   = 1'b1;
      cfg_addr = s_addr;
      cfg_data = s_data;
    end
    lat = 0;
    for (int k = 1; k <= 4 * L; k++) begin
      @(negedge clk);
      start  = 1'b0;
      cfg_we = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
      if (busy_wr) begin
        cfg_we   = 1'($urandom_range(0, 1));
        cfg_addr = AW'($urandom_range(0, 7));
        cfg_data = W'($urandom);
      end
    end
    cfg_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1);
  end

  initial begin
    int lat;
    int last;
    int n_done;
    int waited;
    rst = 1'b1; start = 1'b1; relu_en = 1'b0; in_vec = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_out", 64'(out_vec), 64'd0);
    rst = 1'b0; start = 1'b0;

    // Basic layer, latency and single-cycle done.
    wr_basic();
    run(16'd256, 16'd512, 1'b0, 1'b0, 1'b0, '0, '0, lat);
    check("basic_latency", 64'(lat), 64'd7);
    check("basic_out", 64'(out_vec), 64'h0000_0000_FF00_0200);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);

    run(16'd256, 16'd512, 1'b1, 1'b0, 1'b0, '0, '0, lat);
    check("relu_out", 64'(out_vec), 64'h0000_0000_0000_0200);

    // A write in the start cycle lands in memory but not in that run.
    run(16'd256, 16'd512, 1'b0, 1'b0, 1'b1, 3'd0, 16'd0, lat);
    check("samecyc_old", 64'(out_vec), 64'h0000_0000_FF00_0200);
    run(16'd256, 16'd512, 1'b0, 1'b0, 1'b0, '0, '0, lat);
    check("samecyc_new", 64'(out_vec), 64'h0000_0000_FF00_0180);

    for (int a = 0; a < 4; a++) wr(AW'(a), 16'h7F00);
    wr(4, 16'd0); wr(5, 16'd0);
    run(16'h7F00, 16'h7F00, 1'b0, 1'b0, 1'b0, '0, '0, lat);
    check("sat_pos", 64'(out_vec), 64'h0000_0000_7FFF_7FFF);
    for (int a = 0; a < 4; a++) wr(AW'(a), 16'h8100);
    run(16'h7F00, 16'h7F00, 1'b0, 1'b0, 1'b0, '0, '0, lat);
    check("sat_neg", 64'(out_vec), 64'h0000_0000_8000_8000);

    // Start held high, writes attempted whenever busy.
    wr_basic();
    @(negedge clk);
    in_vec = {16'd512, 16'd256}; relu_en = 1'b0; start = 1'b1;
    last = -1; n_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) begin
        if (last >= 0) check("b2b_spacing", 64'(c - last), 64'(L + 2));
        check("b2b_out", 64'(out_vec), 64'h0000_0000_FF00_0200);
        last = c;
        n_done++;
      end
      cfg_we   = busy;
      cfg_addr = AW'($urandom_range(0, 5));
      cfg_data = W'($urandom);
    end
    start = 1'b0; cfg_we = 1'b0;
    check("b2b_runs", 64'(n_done), 64'd3);
    waited = 0;
    while (busy && waited < 4 * L) begin
      @(negedge clk);
      waited++;
    end
    check("drain_idle", 64'(busy), 64'd0);

    // Randomised runs, checked by the model.
    for (int t = 0; t < 25; t++) begin
      for (int a = 0; a < NCFG; a++) wr(AW'(a), rnd16());
      if (t % 4 == 0) wr(AW'(6 + t % 2), rnd16());
      run(rnd16(), rnd16(), 1'($urandom_range(0, 1)), 1'(t % 2), (t % 3 == 0),
          AW'($urandom_range(0, 5)), rnd16(), lat);
      check("rand_latency", 64'(lat), 64'd7);
    end

    // Reset three cycles into a run.
    wr_basic();
    run(16'd256, 16'd512, 1'b0, 1'b0, 1'b0, '0, '0, lat);
    check("pre_reset_out", 64'(out_vec), 64'h0000_0000_FF00_0200);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_out", 64'(out_vec), 64'd0);
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("midrst_no_done", 64'(n_done), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
